// File: rtl/scan_ctrl.sv
// Multiplexed eight-digit seven-segment scanner with dead-time blanking and frame-synchronous digit buffer.
// Optional leading-zero suppression is enabled by defining SCAN_LZ_BLANK_EN.
module scan_ctrl #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned DEAD    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic        load,
    output logic [6:0]  SSeg,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam int unsigned CNT_MAX = (CLK_DIV > DEAD) ? CLK_DIV : DEAD;
    localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] pending_q, pending_d;
    logic        pend_vld_q, pend_vld_d;
    logic        boundary_s;
    logic [3:0]  nib_s;
    logic        lz_s;
    logic [7:0]  an_d;
    logic [6:0]  sseg_d;
    logic        fd_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0011000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    // State, prescaler, digit index and digit buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BLANK;
            cnt_q      <= CNT_ZERO;
            idx_q      <= 3'd7;
            shadow_q   <= 32'd0;
            pending_q  <= 32'd0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Next-state: dwell/blank sequencing and frame-boundary buffer swap
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        boundary_s = 1'b0;
        if (en) begin
            case (state_q)
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                BLANK: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d    = SHOW;
                        cnt_d      = CNT_ZERO;
                        idx_d      = idx_q + 3'd1;
                        boundary_s = (idx_q == 3'd7);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        shadow_d   = shadow_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        // A load landing on the boundary bypasses pending so it is not lost or shown a frame late
        if (boundary_s) begin
            pend_vld_d = 1'b0;
            if (load) begin
                shadow_d = digits;
            end else if (pend_vld_q) begin
                shadow_d = pending_q;
            end else begin
                shadow_d = shadow_q;
            end
        end else if (load) begin
            pending_d  = digits;
            pend_vld_d = 1'b1;
        end else begin
            pend_vld_d = pend_vld_q;
        end
    end

    // Output decode from current state and index
    always_comb begin
        nib_s = 4'(shadow_q >> {idx_q, 2'b00});
`ifdef SCAN_LZ_BLANK_EN
        lz_s  = (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
`else
        lz_s  = 1'b0;
`endif
        fd_d  = boundary_s;
        if (en && (state_q == SHOW)) begin
            an_d   = ~(8'd1 << idx_q);
            sseg_d = lz_s ? 7'h7F : seg_decode(nib_s);
        end else begin
            an_d   = 8'hFF;
            sseg_d = 7'h7F;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= 8'hFF;
            SSeg       <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            SSeg       <= sseg_d;
            frame_done <= fd_d;
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// Randomized scoreboard bench for scan_ctrl; reference model works from the frame timeline position.
module tb_scan_ctrl;

    localparam int CD = 8;
    localparam int DD = 2;
    localparam int P  = CD + DD;
    localparam int FR = 8 * P;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] digits = 32'd0;
    logic [6:0]  SSeg;
    logic [7:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    longint      m_t;
    logic [31:0] m_shadow;
    logic [31:0] m_pend;
    bit          m_pv;

    scan_ctrl #(.CLK_DIV(CD), .DEAD(DD)) dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .load(load),
        .SSeg(SSeg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Position inside the 8-digit frame, 0 = first SHOW cycle of digit 0
    function automatic int frame_pos(input longint tt);
        return int'((tt + FR - DD) % FR);
    endfunction

    function automatic exp_t model_out(input bit e);
        exp_t x;
        int f, d;
        logic [3:0] nib;
        f = frame_pos(m_t);
        d = f / P;
        x.fd = 1'b0;
        if (e && ((f % P) < CD)) begin
            x.an  = ~(8'd1 << d);
            nib   = m_shadow[d*4 +: 4];
            x.seg = SEG_TAB[nib];
`ifdef SCAN_LZ_BLANK_EN
            if ((d != 0) && ((m_shadow >> (4 * d)) == 32'd0)) x.seg = 7'h7F;
`endif
        end else begin
            x.an  = 8'hFF;
            x.seg = 7'h7F;
        end
        return x;
    endfunction

    task automatic model_reset();
        m_t = 0; m_shadow = 32'd0; m_pend = 32'd0; m_pv = 1'b0;
    endtask

    task automatic cycle(input bit r, input bit e, input bit ld, input logic [31:0] d);
        exp_t x;
        bit bnd;
        @(negedge clk);
        rst = r; en = e; load = ld; digits = d;
        if (r) begin
            model_reset();
            x = '{an: 8'hFF, seg: 7'h7F, fd: 1'b0};
        end else begin
            x = model_out(e);
            bnd = e && (frame_pos(m_t + 1) == 0);
            x.fd = bnd;
            if (bnd) begin
                if (ld) m_shadow = d;
                else if (m_pv) m_shadow = m_pend;
                m_pv = 1'b0;
            end else if (ld) begin
                m_pend = d;
                m_pv = 1'b1;
            end
            if (e) m_t++;
        end
        exp_q.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; (i <= FR) && (frame_pos(m_t) != pos); i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("run_to_reached", 32'(frame_pos(m_t)), 32'(pos));
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_sseg", 32'(SSeg), 32'h7F);
        chk("rst_fd", 32'(frame_done), 32'h0);
    endtask

    // Monitor: pops one expectation per clock and compares against the registered outputs
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("an", 32'(an), 32'(x.an));
                chk("sseg", 32'(SSeg), 32'(x.seg));
                chk("frame_done", 32'(frame_done), 32'(x.fd));
            end
        end
    end

    initial begin
        logic [31:0] rd;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("init_rst_an", 32'(an), 32'hFF);
        chk("init_rst_sseg", 32'(SSeg), 32'h7F);
        chk("init_rst_fd", 32'(frame_done), 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);

        cycle(1'b0, 1'b1, 1'b1, 32'h87654321);
        run(2 * FR);

        run_to(25);
        cycle(1'b0, 1'b1, 1'b1, 32'h000000AF);
        run(2 * FR);

        run_to(15);
        cycle(1'b0, 1'b1, 1'b1, 32'h11111111);
        run_to(47);
        cycle(1'b0, 1'b1, 1'b1, 32'h22222222);
        run(2 * FR);

        run_to(33);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'b0, (i == 7), 32'h13579BDF);
        run(2 * FR);

        run_to(FR - 1);
        cycle(1'b0, 1'b1, 1'b1, 32'h00000105);
        run(FR + 5);

        for (int i = 0; i < 800; i++) begin
            rd = $urandom & (32'hFFFFFFFF >> (4 * $urandom_range(0, 7)));
            cycle(1'b0, ($urandom % 8) != 0, ($urandom % 16) == 0, rd);
        end
        run(FR);

        run_to(34);
        async_reset();
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        run(FR + 20);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
